fp_mul_param: RTL and testbench

Parametrised IEEE-754-style floating-point multiplier: next generation of the team's 32-bit single-precision multiplier, generalised to any exponent/mantissa width. Operands arrive serially over one shared bus with a ready/accept handshake. A multi-cycle shift-add significand datapath computes the product, followed by normalise and round stages. The block adds special-value handling and exception flags, and sits behind the same producer/consumer handshake as the existing multiplier tops.

---
 rtl/fp_mul_param.sv | 209 ++++++++++++++++++++
 tb/tb_fp_mul_param.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_param.sv
// Parametrised floating-point multiplier: serial operand load, shift-add significand
// multiply, normalise, round. Rounding mode selected by FPMUL_ROUND_NEAREST_EN.
module fp_mul_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] inBus,
  input  logic         inReady,
  output logic         inAccept,
  output logic [W-1:0] outBus,
  output logic         resultReady,
  input  logic         resultAccepted,
  output logic [3:0]   flags
);

  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int XW = EXP_W + 2;
  localparam int CW = $clog2(SW + 1);
  localparam logic signed [XW-1:0] EXP_BIAS = XW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0] EXP_ALL  = XW'((1 << EXP_W) - 1);

  typedef enum logic [2:0] {LOAD_A, LOAD_B, ARMED, MUL, NORM, ROUND, DONE} state_t;

  state_t                r_state;
  logic [W-1:0]          r_a;
  logic [W-1:0]          r_b;
  logic                  r_wait_low;
  logic [PW-1:0]         r_prod;
  logic [PW-1:0]         r_mcand;
  logic [SW-1:0]         r_mplier;
  logic [CW-1:0]         r_cnt;
  logic signed [XW-1:0]  r_exp;
  logic                  r_sign;
  logic                  r_special;
  logic [W-1:0]          r_spec_word;
  logic [3:0]            r_spec_flags;
  logic                  r_in_accept;
  logic [W-1:0]          r_out;
  logic [3:0]            r_flags;
  logic                  r_ready;

  logic [EXP_W-1:0]      w_a_exp, w_b_exp;
  logic [MAN_W-1:0]      w_a_frac, w_b_frac;
  logic                  w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic                  w_sign;
  logic [W-1:0]          w_qnan;
  logic signed [XW-1:0]  w_exp_sum;
  logic                  w_is_special;
  logic [W-1:0]          w_spec_word;
  logic [3:0]            w_spec_flags;

  assign w_a_exp  = r_a[W-2:MAN_W];
  assign w_b_exp  = r_b[W-2:MAN_W];
  assign w_a_frac = r_a[MAN_W-1:0];
  assign w_b_frac = r_b[MAN_W-1:0];
  // A zero exponent covers subnormals too: they are flushed to signed zero.
  assign w_a_zero = (w_a_exp == '0);
  assign w_b_zero = (w_b_exp == '0);
  assign w_a_inf  = (&w_a_exp) && (w_a_frac == '0);
  assign w_b_inf  = (&w_b_exp) && (w_b_frac == '0);
  assign w_a_nan  = (&w_a_exp) && (w_a_frac != '0);
  assign w_b_nan  = (&w_b_exp) && (w_b_frac != '0);
  assign w_sign   = r_a[W-1] ^ r_b[W-1];
  assign w_qnan   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  assign w_exp_sum = $signed({2'b00, w_a_exp}) + $signed({2'b00, w_b_exp}) - EXP_BIAS;

  always_comb begin
    w_is_special = 1'b1;
    w_spec_word  = w_qnan;
    w_spec_flags = 4'b0000;
    if (w_a_nan || w_b_nan) begin
      w_spec_word = w_qnan;
    end else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
      w_spec_flags = 4'b1000;
    end else if (w_a_inf || w_b_inf) begin
      w_spec_word = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_a_zero || w_b_zero) begin
      w_spec_word = {w_sign, {(W-1){1'b0}}};
    end else begin
      w_is_special = 1'b0;
    end
  end

  // Normalised product: bit PW-2 is the hidden one, fraction follows, then guard/sticky.
  logic [MAN_W-1:0]      w_frac;
  logic                  w_guard, w_sticky, w_round_up, w_inexact;
  logic [MAN_W:0]        w_mant;
  logic signed [XW-1:0]  w_exp_rnd;
  logic [W-1:0]          w_res_word;
  logic [3:0]            w_res_flags;

  assign w_frac    = r_prod[PW-3 -: MAN_W];
  assign w_guard   = r_prod[PW-3-MAN_W];
  assign w_sticky  = |r_prod[PW-4-MAN_W:0];
  assign w_inexact = w_guard | w_sticky;
`ifdef FPMUL_ROUND_NEAREST_EN
  assign w_round_up = w_guard & (w_sticky | w_frac[0]);
`else
  assign w_round_up = 1'b0;
`endif
  assign w_mant    = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_round_up};
  assign w_exp_rnd = r_exp + $signed({{(XW-1){1'b0}}, w_mant[MAN_W]});

  always_comb begin
    w_res_word  = {r_sign, w_exp_rnd[EXP_W-1:0], w_mant[MAN_W-1:0]};
    w_res_flags = {3'b000, w_inexact};
    if (w_exp_rnd >= EXP_ALL) begin
      w_res_word  = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_res_flags = 4'b0101;
    end else if (w_exp_rnd[XW-1] || (w_exp_rnd == '0)) begin
      w_res_word  = {r_sign, {(W-1){1'b0}}};
      w_res_flags = 4'b0011;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= LOAD_A;
      r_a          <= '0;
      r_b          <= '0;
      r_wait_low   <= 1'b0;
      r_prod       <= '0;
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_cnt        <= '0;
      r_exp        <= '0;
      r_sign       <= 1'b0;
      r_special    <= 1'b0;
      r_spec_word  <= '0;
      r_spec_flags <= '0;
      r_in_accept  <= 1'b0;
      r_out        <= '0;
      r_flags      <= '0;
      r_ready      <= 1'b0;
    end else begin
      r_in_accept <= 1'b0;
      // A held inReady must drop before the loader takes another word.
      if (!inReady) r_wait_low <= 1'b0;
      case (r_state)
        LOAD_A: if (inReady && !r_wait_low) begin
          r_a         <= inBus;
          r_in_accept <= 1'b1;
          r_wait_low  <= 1'b1;
          r_state     <= LOAD_B;
        end
        LOAD_B: if (inReady && !r_wait_low) begin
          r_b         <= inBus;
          r_in_accept <= 1'b1;
          r_wait_low  <= 1'b1;
          r_state     <= ARMED;
        end
        ARMED: if (start) begin
          r_sign       <= w_sign;
          r_exp        <= w_exp_sum;
          r_prod       <= '0;
          r_mcand      <= {{SW{1'b0}}, 1'b1, w_a_frac};
          r_mplier     <= {1'b1, w_b_frac};
          r_cnt        <= '0;
          r_special    <= w_is_special;
          r_spec_word  <= w_spec_word;
          r_spec_flags <= w_spec_flags;
          r_state      <= w_is_special ? ROUND : MUL;
        end
        MUL: begin
          if (r_mplier[0]) r_prod <= r_prod + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CW'(SW - 1)) r_state <= NORM;
        end
        NORM: begin
          // The bit shifted out is folded into bit 0 so it still reaches sticky.
          if (r_prod[PW-1]) begin
            r_prod <= {1'b0, r_prod[PW-1:2], r_prod[1] | r_prod[0]};
            r_exp  <= r_exp + XW'(1);
          end
          r_state <= ROUND;
        end
        ROUND: begin
          r_out   <= r_special ? r_spec_word  : w_res_word;
          r_flags <= r_special ? r_spec_flags : w_res_flags;
          r_state <= DONE;
        end
        DONE: begin
          if (!r_ready) begin
            r_ready <= 1'b1;
          end else if (resultAccepted) begin
            r_ready <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_state <= LOAD_A;
          end
        end
        default: r_state <= LOAD_A;
      endcase
    end
  end

  assign inAccept    = r_in_accept;
  assign outBus      = r_out;
  assign resultReady = r_ready;
  assign flags       = r_flags;

endmodule

// File: tb/tb_fp_mul_param.sv
// Self-checking bench for fp_mul_param: default single precision plus a half-precision
// instance, random operands checked against an arithmetic reference model.
module tb_fp_mul_param;

`ifdef FPMUL_ROUND_NEAREST_EN
  localparam bit RNE = 1'b1;
  localparam logic [31:0] KNOWN_RES = 32'hC3161334;
`else
  localparam bit RNE = 1'b0;
  localparam logic [31:0] KNOWN_RES = 32'hC3161333;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 0, inReady = 0, resultAccepted = 0;
  logic [31:0] inBus = '0;
  logic        inAccept, resultReady;
  logic [31:0] outBus;
  logic [3:0]  flags;

  logic        h_start = 0, h_inReady = 0, h_resultAccepted = 0;
  logic [15:0] h_inBus = '0;
  logic        h_inAccept, h_resultReady;
  logic [15:0] h_outBus;
  logic [3:0]  h_flags;

  int checks = 0;
  int errors = 0;

  fp_mul_param dut (
    .clk(clk), .rst(rst), .start(start), .inBus(inBus), .inReady(inReady),
    .inAccept(inAccept), .outBus(outBus), .resultReady(resultReady),
    .resultAccepted(resultAccepted), .flags(flags)
  );

  fp_mul_param #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .start(h_start), .inBus(h_inBus), .inReady(h_inReady),
    .inAccept(h_inAccept), .outBus(h_outBus), .resultReady(h_resultReady),
    .resultAccepted(h_resultAccepted), .flags(h_flags)
  );

  // Reference: exact integer product, rounded by comparing the discarded remainder to half an ulp.
  function automatic logic [35:0] ref_mul(input int ew, input int mw, input logic [31:0] a, input logic [31:0] b);
    longint allones, bias, ea, eb, fa, fb, p, e, q, rem, half, word, sgn, qnan;
    int sh;
    bit a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, inx;
    logic [3:0] fl;
    allones = (longint'(1) << ew) - 1;
    bias    = (longint'(1) << (ew - 1)) - 1;
    ea = longint'(a >> mw) & allones;
    eb = longint'(b >> mw) & allones;
    fa = longint'(a) & ((longint'(1) << mw) - 1);
    fb = longint'(b) & ((longint'(1) << mw) - 1);
    sgn = longint'(a[ew+mw] ^ b[ew+mw]) << (ew + mw);
    qnan = (allones << mw) | (longint'(1) << (mw - 1));
    a_zero = (ea == 0); b_zero = (eb == 0);
    a_inf = (ea == allones) && (fa == 0); b_inf = (eb == allones) && (fb == 0);
    a_nan = (ea == allones) && (fa != 0); b_nan = (eb == allones) && (fb != 0);
    fl = 4'b0000;
    if (a_nan || b_nan) word = qnan;
    else if ((a_inf && b_zero) || (b_inf && a_zero)) begin word = qnan; fl = 4'b1000; end
    else if (a_inf || b_inf) word = sgn | (allones << mw);
    else if (a_zero || b_zero) word = sgn;
    else begin
      p = ((longint'(1) << mw) | fa) * ((longint'(1) << mw) | fb);
      e = ea + eb - bias;
      sh = mw;
      if (p >= (longint'(1) << (2 * mw + 1))) begin sh = mw + 1; e = e + 1; end
      q = p >> sh;
      rem = p - (q << sh);
      half = longint'(1) << (sh - 1);
      inx = (rem != 0);
      if (RNE && ((rem > half) || ((rem == half) && (q % 2 == 1)))) q = q + 1;
      if (q == (longint'(1) << (mw + 1))) begin q = q >> 1; e = e + 1; end
      if (e >= allones) begin word = sgn | (allones << mw); fl = 4'b0101; end
      else if (e <= 0) begin word = sgn; fl = 4'b0011; end
      else begin word = sgn | (e << mw) | (q & ((longint'(1) << mw) - 1)); fl = {3'b000, inx}; end
    end
    return {fl, word[31:0]};
  endfunction

  function automatic logic [31:0] rand_op(input int ew, input int mw);
    longint allones, bias, e, f;
    int r;
    allones = (longint'(1) << ew) - 1;
    bias = (longint'(1) << (ew - 1)) - 1;
    r = int'($urandom_range(0, 11));
    f = longint'($urandom) & ((longint'(1) << mw) - 1);
    if (r == 0) e = 0;
    else if (r == 1) begin e = allones; if ($urandom_range(0, 1) == 0) f = 0; end
    else if (r < 7) e = bias + longint'($urandom_range(0, 8)) - 4;
    else e = longint'($urandom_range(1, 32'(allones - 1)));
    return 32'((longint'($urandom_range(0, 1)) << (ew + mw)) | (e << mw) | f);
  endfunction

  task automatic load_word(input logic [31:0] w);
    int n;
    @(negedge clk); inBus = w; inReady = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!inAccept && n < 20);
    inReady = 1'b0;
  endtask

  task automatic go(output logic [31:0] word, output logic [3:0] flg, output int lat);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    lat = 0;
    while (!resultReady && lat < 200) begin @(negedge clk); lat++; end
    word = outBus; flg = flags;
    resultAccepted = 1'b1;
    @(negedge clk) resultAccepted = 1'b0;
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] word, output logic [3:0] flg, output int lat);
    load_word(a); load_word(b); go(word, flg, lat);
  endtask

  task automatic run_mul_h(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] word, output logic [3:0] flg, output int lat);
    int n;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); h_inBus = (k == 0) ? a : b; h_inReady = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!h_inAccept && n < 20);
      h_inReady = 1'b0;
    end
    @(negedge clk) h_start = 1'b1;
    @(negedge clk) h_start = 1'b0;
    lat = 0;
    while (!h_resultReady && lat < 200) begin @(negedge clk); lat++; end
    word = h_outBus; flg = h_flags;
    h_resultAccepted = 1'b1;
    @(negedge clk) h_resultAccepted = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (inAccept !== 1'b0) begin errors++; $display("FAIL reset_inAccept got %b want 0", inAccept); end
    checks++; if (resultReady !== 1'b0) begin errors++; $display("FAIL reset_resultReady got %b want 0", resultReady); end
    checks++; if (outBus !== 32'h0) begin errors++; $display("FAIL reset_outBus got %h want 0", outBus); end
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags got %b want 0000", flags); end
    $display("reset: inAccept=%b resultReady=%b outBus=%h flags=%b", inAccept, resultReady, outBus, flags);
  endtask

  task automatic test_known();
    logic [31:0] w; logic [3:0] f; int lat;
    run_mul(32'hBE99999A, 32'h43FA2000, w, f, lat);
    $display("known: BE99999A x 43FA2000 -> %h flags=%b lat=%0d", w, f, lat);
    checks++; if (w !== KNOWN_RES) begin errors++; $display("FAIL known_word got %h want %h", w, KNOWN_RES); end
    checks++; if (f !== 4'b0001) begin errors++; $display("FAIL known_flags got %b want 0001", f); end
    checks++; if (lat != 27) begin errors++; $display("FAIL known_latency got %0d want 27", lat); end
  endtask

  task automatic test_specials();
    logic [31:0] va [4] = '{32'h7F800000, 32'h7F000000, 32'h00800000, 32'h7FC01234};
    logic [31:0] vb [4] = '{32'h00000000, 32'h40000000, 32'h3F000000, 32'h3F800000};
    int          vl [4] = '{2, 27, 27, 2};
    logic [31:0] w; logic [3:0] f; int lat; logic [35:0] ex;
    for (int i = 0; i < 4; i++) begin
      ex = ref_mul(8, 23, va[i], vb[i]);
      run_mul(va[i], vb[i], w, f, lat);
      $display("special: %h x %h -> %h flags=%b lat=%0d", va[i], vb[i], w, f, lat);
      checks++; if (w !== ex[31:0]) begin errors++; $display("FAIL special_word[%0d] got %h want %h", i, w, ex[31:0]); end
      checks++; if (f !== ex[35:32]) begin errors++; $display("FAIL special_flags[%0d] got %b want %b", i, f, ex[35:32]); end
      checks++; if (lat != vl[i]) begin errors++; $display("FAIL special_latency[%0d] got %0d want %0d", i, lat, vl[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, w; logic [3:0] f; int lat, want_lat; logic [35:0] ex;
    for (int i = 0; i < 40; i++) begin
      a = rand_op(8, 23); b = rand_op(8, 23);
      ex = ref_mul(8, 23, a, b);
      want_lat = ((a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
                  (b[30:23] == 8'h00) || (b[30:23] == 8'hFF)) ? 2 : 27;
      run_mul(a, b, w, f, lat);
      $display("random %0d: %h x %h -> %h flags=%b lat=%0d", i, a, b, w, f, lat);
      checks++; if (w !== ex[31:0]) begin errors++; $display("FAIL random_word[%0d] got %h want %h", i, w, ex[31:0]); end
      checks++; if (f !== ex[35:32]) begin errors++; $display("FAIL random_flags[%0d] got %b want %b", i, f, ex[35:32]); end
      checks++; if (lat != want_lat) begin errors++; $display("FAIL random_latency[%0d] got %0d want %0d", i, lat, want_lat); end
    end
  endtask

  task automatic test_held_ready();
    logic [31:0] a, b, w; logic [3:0] f; int lat, pulses, seen; logic [35:0] ex;
    a = 32'h40A00000; b = 32'hC0400000;
    @(negedge clk); inBus = a; inReady = 1'b1;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); if (inAccept) pulses++;
      inBus = b;
    end
    inReady = 1'b0;
    @(negedge clk); if (inAccept) pulses++;
    checks++; if (pulses != 1) begin errors++; $display("FAIL held_pulses got %0d want 1", pulses); end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    seen = 0;
    repeat (40) begin @(negedge clk); if (resultReady) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL start_in_load_b got %0d ready cycles want 0", seen); end
    load_word(b); go(w, f, lat);
    ex = ref_mul(8, 23, a, b);
    $display("held: pulses=%0d ready_after_early_start=%0d result=%h flags=%b lat=%0d", pulses, seen, w, f, lat);
    checks++; if (w !== ex[31:0]) begin errors++; $display("FAIL held_word got %h want %h", w, ex[31:0]); end
    checks++; if (f !== ex[35:32]) begin errors++; $display("FAIL held_flags got %b want %b", f, ex[35:32]); end
    checks++; if (lat != 27) begin errors++; $display("FAIL held_latency got %0d want 27", lat); end
  endtask

  task automatic test_busy_ignored();
    logic [31:0] a, b, w; logic [3:0] f; int lat, acc; logic [35:0] ex;
    a = 32'h3FC00000; b = 32'h3FC00001;
    ex = ref_mul(8, 23, a, b);
    load_word(a); load_word(b);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0; inReady = 1'b1; inBus = 32'h12345678; resultAccepted = 1'b1;
    acc = 0; lat = 0;
    while (!resultReady && lat < 200) begin
      @(negedge clk); lat++;
      if (inAccept) acc++;
      if (lat == 5) resultAccepted = 1'b0;
      if (lat == 25) inReady = 1'b0;
    end
    w = outBus; f = flags;
    resultAccepted = 1'b1;
    @(negedge clk) resultAccepted = 1'b0;
    $display("busy: accepts=%0d result=%h flags=%b lat=%0d", acc, w, f, lat);
    checks++; if (acc != 0) begin errors++; $display("FAIL busy_accepts got %0d want 0", acc); end
    checks++; if (w !== ex[31:0]) begin errors++; $display("FAIL busy_word got %h want %h", w, ex[31:0]); end
    checks++; if (f !== ex[35:32]) begin errors++; $display("FAIL busy_flags got %b want %b", f, ex[35:32]); end
    checks++; if (lat != 27) begin errors++; $display("FAIL busy_latency got %0d want 27", lat); end
  endtask

  task automatic test_rst_mid();
    logic [31:0] w; logic [3:0] f; int lat;
    load_word(32'h3FA00000); load_word(32'h40100000);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    $display("rst_mid: outBus=%h flags=%b resultReady=%b inAccept=%b", outBus, flags, resultReady, inAccept);
    checks++; if (outBus !== 32'h0) begin errors++; $display("FAIL rst_outBus got %h want 0", outBus); end
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL rst_flags got %b want 0000", flags); end
    checks++; if (resultReady !== 1'b0) begin errors++; $display("FAIL rst_resultReady got %b want 0", resultReady); end
    checks++; if (inAccept !== 1'b0) begin errors++; $display("FAIL rst_inAccept got %b want 0", inAccept); end
    @(negedge clk) rst = 1'b0;
    run_mul(32'h3F800000, 32'h40400000, w, f, lat);
    $display("after_rst: 3F800000 x 40400000 -> %h flags=%b lat=%0d", w, f, lat);
    checks++; if (w !== 32'h40400000) begin errors++; $display("FAIL after_rst_word got %h want 40400000", w); end
    checks++; if (f !== 4'b0000) begin errors++; $display("FAIL after_rst_flags got %b want 0000", f); end
    checks++; if (lat != 27) begin errors++; $display("FAIL after_rst_latency got %0d want 27", lat); end
  endtask

  task automatic test_half();
    logic [15:0] a, b, w; logic [3:0] f; int lat, want_lat; logic [35:0] ex;
    run_mul_h(16'h3C00, 16'hC000, w, f, lat);
    $display("half: 3C00 x C000 -> %h flags=%b lat=%0d", w, f, lat);
    checks++; if (w !== 16'hC000) begin errors++; $display("FAIL half_known_word got %h want c000", w); end
    checks++; if (f !== 4'b0000) begin errors++; $display("FAIL half_known_flags got %b want 0000", f); end
    checks++; if (lat != 14) begin errors++; $display("FAIL half_known_latency got %0d want 14", lat); end
    for (int i = 0; i < 20; i++) begin
      a = 16'(rand_op(5, 10)); b = 16'(rand_op(5, 10));
      ex = ref_mul(5, 10, {16'h0, a}, {16'h0, b});
      want_lat = ((a[14:10] == 5'h00) || (a[14:10] == 5'h1F) ||
                  (b[14:10] == 5'h00) || (b[14:10] == 5'h1F)) ? 2 : 14;
      run_mul_h(a, b, w, f, lat);
      $display("half random %0d: %h x %h -> %h flags=%b lat=%0d", i, a, b, w, f, lat);
      checks++; if (w !== ex[15:0]) begin errors++; $display("FAIL half_word[%0d] got %h want %h", i, w, ex[15:0]); end
      checks++; if (f !== ex[35:32]) begin errors++; $display("FAIL half_flags[%0d] got %b want %b", i, f, ex[35:32]); end
      checks++; if (lat != want_lat) begin errors++; $display("FAIL half_latency[%0d] got %0d want %0d", i, lat, want_lat); end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_known();
    test_specials();
    test_random();
    test_held_ready();
    test_busy_ignored();
    test_rst_mid();
    test_half();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
